coef_bank_ctrl: RTL and testbench

Double-buffered coefficient bank controller between the SPI register interface and the FIR datapath in filter_top.
- SPI register writes land in a shadow bank.
- The FIR always sees a stable active bank.
- A commit command arms a swap. The swap copies shadow to active atomically on the next FIR sample boundary, then holds off further writes while the FIR pipeline flushes.

---
 rtl/coef_bank_pkg.sv | 28 ++
 rtl/coef_regfile.sv | 75 +++++++
 rtl/coef_bank_ctrl.sv | 160 ++++++++++++++++
 tb/tb_coef_bank_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coef_bank_pkg.sv
// Shared types and constants for the double-buffered coefficient bank controller.
// The STATUS word layout is {state[1:0], 2'b00, commit_count[7:0]}.
package coef_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2
  } coef_state_e;

  localparam logic [7:0] ACTIVE_BASE_DEF = 8'h40;
  localparam logic [7:0] CTRL_ADDR_DEF   = 8'hF0;
  localparam logic [7:0] STATUS_ADDR_DEF = 8'hF1;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_ABORT_BIT  = 1;

  localparam int STATUS_W       = 12;
  localparam int STATUS_COUNT_W = 8;

  function automatic logic [STATUS_W-1:0] pack_status(
    input coef_state_e               st,
    input logic [STATUS_COUNT_W-1:0] cnt
  );
    pack_status = {st, 2'b00, cnt};
  endfunction

endpackage

// File: rtl/coef_regfile.sv
// Shadow/active coefficient register pair: single write port into the shadow bank,
// bulk shadow-to-active copy, combinational read of either bank and a flat active bus.
module coef_regfile
  import coef_bank_pkg::*;
#(
  parameter int NUM_TAPS = 16,
  parameter int COEF_W   = 12,
  parameter int IDX_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [COEF_W-1:0]          wr_data,
  input  logic                       copy_en,
  input  logic [IDX_W-1:0]           rd_idx_shadow,
  input  logic [IDX_W-1:0]           rd_idx_active,
  output logic [COEF_W-1:0]          rd_shadow,
  output logic [COEF_W-1:0]          rd_active,
  output logic [NUM_TAPS*COEF_W-1:0] active_flat
);

  logic [COEF_W-1:0] shadow_q [NUM_TAPS];
  logic [COEF_W-1:0] shadow_d [NUM_TAPS];
  logic [COEF_W-1:0] active_q [NUM_TAPS];
  logic [COEF_W-1:0] active_d [NUM_TAPS];

  // The copy reads the pre-edge shadow, so a write on the swap edge lands after the copy.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (wr_en && (int'(wr_idx) == k)) begin
        shadow_d[k] = wr_data;
      end else begin
        shadow_d[k] = shadow_q[k];
      end
      if (copy_en) begin
        active_d[k] = shadow_q[k];
      end else begin
        active_d[k] = active_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  always_comb begin
    if ({1'b0, rd_idx_shadow} < (IDX_W+1)'(NUM_TAPS)) begin
      rd_shadow = shadow_q[rd_idx_shadow];
    end else begin
      rd_shadow = '0;
    end
    if ({1'b0, rd_idx_active} < (IDX_W+1)'(NUM_TAPS)) begin
      rd_active = active_q[rd_idx_active];
    end else begin
      rd_active = '0;
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
    assign active_flat[g*COEF_W +: COEF_W] = active_q[g];
  end

endmodule

// File: rtl/coef_bank_ctrl.sv
// Double-buffered coefficient bank controller: register writes fill the shadow bank, a
// committed swap copies it to the active bank on a sample boundary, then writes are locked out.
module coef_bank_ctrl
  import coef_bank_pkg::*;
#(
  parameter int               NUM_TAPS    = 16,
  parameter int               COEF_W      = 12,
  parameter int               ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] ACTIVE_BASE = ACTIVE_BASE_DEF,
  parameter logic [ADDR_W-1:0] CTRL_ADDR   = CTRL_ADDR_DEF,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = STATUS_ADDR_DEF,
  parameter int               HOLD_CYC    = 4
) (
  input  logic                       Clk,
  input  logic                       Hlt,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [COEF_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [COEF_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       sample_strobe,
  output logic [NUM_TAPS*COEF_W-1:0] coef_active,
  output logic                       armed,
  output logic                       commit_done,
  output logic                       wr_err
);

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int HC_W  = $clog2(HOLD_CYC + 1);

  coef_state_e               state_q, state_d;
  logic [HC_W-1:0]           hold_cnt_q, hold_cnt_d;
  logic [STATUS_COUNT_W-1:0] commit_count_q, commit_count_d;
  logic [COEF_W-1:0]         rd_data_q, rd_data_d;
  logic                      rd_valid_q, armed_q, commit_done_q, wr_err_q;

  logic              wr_is_shadow, wr_is_ctrl, wr_ok, wr_rej;
  logic              shadow_wr, ctrl_commit, ctrl_abort, swap;
  logic [ADDR_W-1:0] rd_off;
  logic              rd_is_shadow, rd_is_active;
  logic [COEF_W-1:0] rd_shadow_val, rd_active_val;

  always_comb begin
    wr_is_shadow = (wr_addr < ADDR_W'(NUM_TAPS));
    wr_is_ctrl   = (wr_addr == CTRL_ADDR);
    wr_ok        = wr_en && (state_q != ST_HOLD) && (wr_is_shadow || wr_is_ctrl);
    wr_rej       = wr_en && !wr_ok;
    shadow_wr    = wr_ok && wr_is_shadow;
    ctrl_commit  = wr_ok && wr_is_ctrl && wr_data[CTRL_COMMIT_BIT];
    ctrl_abort   = wr_ok && wr_is_ctrl && wr_data[CTRL_ABORT_BIT];
  end

  // Abort takes priority over a coincident sample strobe in ARMED.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    commit_count_d = commit_count_q;
    swap           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_commit) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (ctrl_abort) begin
          state_d = ST_IDLE;
        end else if (sample_strobe) begin
          swap           = 1'b1;
          state_d        = ST_HOLD;
          hold_cnt_d     = HC_W'(HOLD_CYC);
          commit_count_d = commit_count_q + 8'd1;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q <= HC_W'(1)) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HC_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Reads sample the pre-edge banks, so a same-cycle write is not visible yet.
  always_comb begin
    rd_off       = rd_addr - ACTIVE_BASE;
    rd_is_shadow = (rd_addr < ADDR_W'(NUM_TAPS));
    rd_is_active = (rd_off < ADDR_W'(NUM_TAPS));
    if (!rd_en) begin
      rd_data_d = rd_data_q;
    end else if (rd_is_shadow) begin
      rd_data_d = rd_shadow_val;
    end else if (rd_is_active) begin
      rd_data_d = rd_active_val;
    end else if (rd_addr == STATUS_ADDR) begin
      rd_data_d = COEF_W'(pack_status(state_q, commit_count_q));
    end else begin
      rd_data_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Hlt) begin
      state_q        <= ST_IDLE;
      hold_cnt_q     <= '0;
      commit_count_q <= 8'h00;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      armed_q        <= 1'b0;
      commit_done_q  <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      commit_count_q <= commit_count_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_en;
      armed_q        <= (state_d == ST_ARMED);
      commit_done_q  <= swap;
      wr_err_q       <= wr_rej;
    end
  end

  coef_regfile #(
    .NUM_TAPS (NUM_TAPS),
    .COEF_W   (COEF_W),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk           (Clk),
    .rst           (Hlt),
    .wr_en         (shadow_wr),
    .wr_idx        (wr_addr[IDX_W-1:0]),
    .wr_data       (wr_data),
    .copy_en       (swap),
    .rd_idx_shadow (rd_addr[IDX_W-1:0]),
    .rd_idx_active (rd_off[IDX_W-1:0]),
    .rd_shadow     (rd_shadow_val),
    .rd_active     (rd_active_val),
    .active_flat   (coef_active)
  );

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign armed       = armed_q;
  assign commit_done = commit_done_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_coef_bank_ctrl.sv
// Self-checking bench for coef_bank_ctrl: feature tasks with inline checks plus a
// read-data scoreboard that is filled when a read is issued and drained on rd_valid.
module tb_coef_bank_ctrl;

  localparam int NT = 16;
  localparam int CW = 12;
  localparam int AW = 8;

  logic              Clk = 1'b0;
  logic              Hlt = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [CW-1:0]     wr_data = '0;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [CW-1:0]     rd_data;
  logic              rd_valid;
  logic              sample_strobe = 1'b0;
  logic [NT*CW-1:0]  coef_active;
  logic              armed, commit_done, wr_err;

  logic [CW-1:0] shadow_m [NT];
  logic [CW-1:0] active_m [NT];
  logic [7:0]    count_m;
  logic [CW-1:0] exp_q [$];
  logic [CW-1:0] mon_exp;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  coef_bank_ctrl dut (
    .Clk           (Clk),
    .Hlt           (Hlt),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .sample_strobe (sample_strobe),
    .coef_active   (coef_active),
    .armed         (armed),
    .commit_done   (commit_done),
    .wr_err        (wr_err)
  );

  always #5 Clk = ~Clk;

  // Scoreboard drain: every rd_valid pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (rd_valid === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_unexpected: rd_valid=1 with no read outstanding, rd_data=%h", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) $display("FAIL rd_data: got %h expected %h", rd_data, mon_exp);
        else pass_cnt++;
      end
    end
  end

  function automatic logic [NT*CW-1:0] flat_m();
    logic [NT*CW-1:0] f;
    for (int k = 0; k < NT; k++) f[k*CW +: CW] = active_m[k];
    return f;
  endfunction

  function automatic logic [CW-1:0] status_m(input logic [1:0] st);
    return {st, 2'b00, count_m};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [CW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [CW-1:0] e);
    exp_q.push_back(e);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    total_cnt++;
    if (rd_valid !== 1'b1) $display("FAIL rd_valid_latency: addr %h got %b expected 1", a, rd_valid);
    else pass_cnt++;
  endtask

  task automatic strobe_swap();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    for (int k = 0; k < NT; k++) active_m[k] = shadow_m[k];
    count_m = count_m + 8'd1;
  endtask

  task automatic test_reset();
    Hlt = 1'b1;
    tick(); tick();
    Hlt = 1'b0;
    for (int k = 0; k < NT; k++) begin shadow_m[k] = '0; active_m[k] = '0; end
    count_m = 8'h00;
    total_cnt++;
    if ({armed, commit_done, wr_err, rd_valid} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {armed, commit_done, wr_err, rd_valid});
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== 12'h000) $display("FAIL reset_rd_data: got %h expected 000", rd_data);
    else pass_cnt++;
    total_cnt++;
    if (coef_active !== flat_m()) $display("FAIL reset_active: got %h expected 0", coef_active);
    else pass_cnt++;
    do_read(8'h00, 12'h000);
    do_read(8'h40, 12'h000);
    do_read(8'hF1, 12'h000);
  endtask

  task automatic test_commit();
    wr(8'h00, 12'h123); shadow_m[0] = 12'h123;
    wr(8'h0F, 12'hABC); shadow_m[15] = 12'hABC;
    wr(8'hF0, 12'h001);
    total_cnt++;
    if (armed !== 1'b1) $display("FAIL commit_armed: got %b expected 1", armed);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if (coef_active !== flat_m()) $display("FAIL commit_pre_strobe: got %h expected %h", coef_active, flat_m());
    else pass_cnt++;
    strobe_swap();
    total_cnt++;
    if (coef_active !== flat_m()) $display("FAIL commit_swap: got %h expected %h", coef_active, flat_m());
    else pass_cnt++;
    total_cnt++;
    if ({commit_done, armed} !== 2'b10) $display("FAIL commit_done_pulse: got %b expected 10", {commit_done, armed});
    else pass_cnt++;
    do_read(8'hF1, status_m(2'd2));
    total_cnt++;
    if (commit_done !== 1'b0) $display("FAIL commit_done_width: got %b expected 0", commit_done);
    else pass_cnt++;
    tick(); tick();
    do_read(8'hF1, status_m(2'd2));
    do_read(8'hF1, status_m(2'd0));
    do_read(8'h40, 12'h123);
    do_read(8'h4F, 12'hABC);
    do_read(8'h0F, 12'hABC);
  endtask

  task automatic test_abort();
    wr(8'h03, 12'h555); shadow_m[3] = 12'h555;
    wr(8'hF0, 12'h001);
    wr_en = 1'b1; wr_addr = 8'hF0; wr_data = 12'h002; sample_strobe = 1'b1;
    tick();
    wr_en = 1'b0; sample_strobe = 1'b0;
    total_cnt++;
    if ({armed, commit_done} !== 2'b00) $display("FAIL abort_flags: got %b expected 00", {armed, commit_done});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (commit_done !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", commit_done);
    else pass_cnt++;
    total_cnt++;
    if (coef_active !== flat_m()) $display("FAIL abort_no_swap: got %h expected %h", coef_active, flat_m());
    else pass_cnt++;
    do_read(8'h43, 12'h000);
    do_read(8'hF1, status_m(2'd0));
  endtask

  task automatic test_lockout_errors();
    logic [AW-1:0] bad [4];
    bad[0] = 8'h40; bad[1] = 8'hF1; bad[2] = 8'h80; bad[3] = 8'h10;
    wr(8'hF0, 12'h001);
    strobe_swap();
    wr(8'h05, 12'h777);
    total_cnt++;
    if (wr_err !== 1'b1) $display("FAIL hold_shadow_wr_err: got %b expected 1", wr_err);
    else pass_cnt++;
    wr(8'hF0, 12'h001);
    total_cnt++;
    if (wr_err !== 1'b1) $display("FAIL hold_ctrl_wr_err: got %b expected 1", wr_err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (wr_err !== 1'b0) $display("FAIL wr_err_width: got %b expected 0", wr_err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (armed !== 1'b0) $display("FAIL hold_ctrl_ignored: got %b expected 0", armed);
    else pass_cnt++;
    do_read(8'hF1, status_m(2'd0));
    do_read(8'h05, 12'h000);
    for (int i = 0; i < 4; i++) begin
      wr(bad[i], 12'hFFF);
      total_cnt++;
      if (wr_err !== 1'b1) $display("FAIL bad_addr_wr_err: addr %h got %b expected 1", bad[i], wr_err);
      else pass_cnt++;
    end
    total_cnt++;
    if ({armed, coef_active} !== {1'b0, flat_m()}) $display("FAIL bad_addr_side_effect: armed %b active %h", armed, coef_active);
    else pass_cnt++;
    do_read(8'h40, active_m[0]);
    do_read(8'hF1, status_m(2'd0));
    do_read(8'h80, 12'h000);
    // Same-cycle read and write of one shadow entry.
    exp_q.push_back(shadow_m[7]);
    wr_en = 1'b1; wr_addr = 8'h07; wr_data = 12'h9A5;
    rd_en = 1'b1; rd_addr = 8'h07;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    shadow_m[7] = 12'h9A5;
    total_cnt++;
    if (wr_err !== 1'b0) $display("FAIL good_wr_no_err: got %b expected 0", wr_err);
    else pass_cnt++;
    do_read(8'h07, 12'h9A5);
  endtask

  task automatic test_same_edge();
    wr_en = 1'b1; wr_addr = 8'hF0; wr_data = 12'h001; sample_strobe = 1'b1;
    tick();
    wr_en = 1'b0; sample_strobe = 1'b0;
    total_cnt++;
    if ({armed, coef_active} !== {1'b1, flat_m()}) $display("FAIL same_edge_no_swap: armed %b active %h", armed, coef_active);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (commit_done !== 1'b0) $display("FAIL same_edge_no_done: got %b expected 0", commit_done);
    else pass_cnt++;
    repeat (8) tick();
    total_cnt++;
    if (coef_active !== flat_m()) $display("FAIL same_edge_wait: got %h expected %h", coef_active, flat_m());
    else pass_cnt++;
    strobe_swap();
    total_cnt++;
    if ({commit_done, coef_active} !== {1'b1, flat_m()}) $display("FAIL same_edge_late_swap: done %b active %h", commit_done, coef_active);
    else pass_cnt++;
    repeat (4) tick();
  endtask

  task automatic test_wrap_and_reset();
    int n;
    int pulses;
    n = 256 - int'(count_m);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      wr(8'hF0, 12'h001);
      strobe_swap();
      if (commit_done === 1'b1) pulses++;
      repeat (4) tick();
    end
    total_cnt++;
    if (pulses != n) $display("FAIL wrap_done_count: got %0d expected %0d", pulses, n);
    else pass_cnt++;
    do_read(8'hF1, status_m(2'd0));
    wr(8'h02, 12'h3C3); shadow_m[2] = 12'h3C3;
    wr(8'hF0, 12'h001);
    total_cnt++;
    if (armed !== 1'b1) $display("FAIL hlt_pre_armed: got %b expected 1", armed);
    else pass_cnt++;
    Hlt = 1'b1; sample_strobe = 1'b1;
    tick();
    Hlt = 1'b0; sample_strobe = 1'b0;
    for (int k = 0; k < NT; k++) begin shadow_m[k] = '0; active_m[k] = '0; end
    count_m = 8'h00;
    total_cnt++;
    if ({armed, commit_done, coef_active} !== {2'b00, flat_m()})
      $display("FAIL hlt_armed: armed %b done %b active %h", armed, commit_done, coef_active);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (commit_done !== 1'b0) $display("FAIL hlt_no_done: got %b expected 0", commit_done);
    else pass_cnt++;
    do_read(8'h02, 12'h000);
    do_read(8'h47, 12'h000);
    do_read(8'hF1, 12'h000);
  endtask

  initial begin
    test_reset();
    test_commit();
    test_abort();
    test_lockout_errors();
    test_same_edge();
    test_wrap_and_reset();
    tick(); tick();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL rd_outstanding: %0d reads never returned, expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
